// File: rtl/seg7_score_ctrl_if.sv
// seg7_score_ctrl_if: score-update valid/ready handshake between game logic and the display controller
interface seg7_score_ctrl_if;
    logic        upd_valid;
    logic [13:0] upd_value;
    logic        upd_ready;
    modport master (output upd_valid, output upd_value, input upd_ready);
    modport slave (input upd_valid, input upd_value, output upd_ready);
endinterface

// File: rtl/seg7_score_ctrl.sv
// seg7_score_ctrl: binary-to-BCD score sequencer with scan prescaler, leading-zero blanking and blink
module seg7_score_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLINK_DIV = 256,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic              CLK,
    input  logic              CLR,
    seg7_score_ctrl_if.slave  upd,
    input  logic              blink_en,
    output logic              scan_tick,
    output logic              busy,
    output logic [3:0]        dig0,
    output logic [3:0]        dig1,
    output logic [3:0]        dig2,
    output logic [3:0]        dig3
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [15:0] RST_DIG = BLANK_LZ ? 16'hFFF0 : 16'h0000;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
    state_t        state, state_n;
    logic [13:0]   bin, bin_n;
    logic [15:0]   bcd, bcd_n, adj, blanked;
    logic [15:0]   stored, stored_n;
    logic [3:0]    cnt, cnt_n;
    logic [SW-1:0] pre, pre_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic          blink_wrap, z3, z2, z1;
    // add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // leading zeros are blanked from the thousands digit downward; ones digit always shows
    always_comb begin
        z3 = bcd[15:12] == 4'd0;
        z2 = z3 && bcd[11:8] == 4'd0;
        z1 = z2 && bcd[7:4] == 4'd0;
        blanked = {BLANK_LZ && z3 ? 4'hF : bcd[15:12],
                   BLANK_LZ && z2 ? 4'hF : bcd[11:8],
                   BLANK_LZ && z1 ? 4'hF : bcd[7:4],
                   bcd[3:0]};
    end
    // conversion FSM next state and datapath
    always_comb begin
        state_n  = state;
        bin_n    = bin;
        bcd_n    = bcd;
        cnt_n    = cnt;
        stored_n = stored;
        case (state)
            IDLE: if (upd.upd_valid) begin
                bin_n   = upd.upd_value;
                state_n = LOAD;
            end
            LOAD: begin
                bin_n   = bin > 14'd9999 ? 14'd9999 : bin;
                bcd_n   = '0;
                cnt_n   = 4'd14;
                state_n = SHIFT;
            end
            SHIFT: begin
                {bcd_n, bin_n} = {adj, bin} << 1;
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? COMMIT : SHIFT;
            end
            default: begin
                stored_n = blanked;
                state_n  = IDLE;
            end
        endcase
    end
    // free-running scan prescaler and blink phase tracking
    always_comb begin
        pre_n      = pre == SW'(SCAN_DIV - 1) ? '0 : pre + 1'b1;
        blink_wrap = scan_tick && bcnt == BW'(BLINK_DIV - 1);
        bcnt_n     = !blink_en ? '0 : !scan_tick ? bcnt : blink_wrap ? '0 : bcnt + 1'b1;
        phase_n    = blink_en && (phase ^ blink_wrap);
    end
    // state and registered outputs; CLR overrides everything
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state                    <= IDLE;
            bin                      <= '0;
            bcd                      <= '0;
            cnt                      <= '0;
            stored                   <= RST_DIG;
            pre                      <= '0;
            bcnt                     <= '0;
            phase                    <= 1'b0;
            scan_tick                <= 1'b0;
            busy                     <= 1'b0;
            upd.upd_ready            <= 1'b1;
            {dig3, dig2, dig1, dig0} <= RST_DIG;
        end else begin
            state                    <= state_n;
            bin                      <= bin_n;
            bcd                      <= bcd_n;
            cnt                      <= cnt_n;
            stored                   <= stored_n;
            pre                      <= pre_n;
            bcnt                     <= bcnt_n;
            phase                    <= phase_n;
            scan_tick                <= pre_n == SW'(SCAN_DIV - 1);
            busy                     <= state_n != IDLE;
            upd.upd_ready            <= state_n == IDLE;
            {dig3, dig2, dig1, dig0} <= phase_n ? 16'hFFFF : stored_n;
        end
    end
endmodule
